// File: rtl/dff_reg_pkg.sv
// Shared defaults for the generic holding register.
// Keeps the default bus width in one place for every instantiation site.
package dff_reg_pkg;
  localparam int unsigned DFF_DEFAULT_WIDTH = 4;
endpackage

// File: rtl/dff_reg.sv
// WIDTH-bit rising-edge D register with synchronous active-high reset to RST_VAL.
// One cycle D-to-Q latency; no enable and no combinational path from D to Q.
module dff_reg
  import dff_reg_pkg::*;
#(
  parameter int unsigned          WIDTH   = DFF_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0]     RST_VAL = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  always_comb begin
    q_d = D;
  end

  // Reset is only looked at on the rising edge, so it overrides D at that edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q = q_q;

endmodule

// File: tb/tb_dff_reg.sv
// Bench for dff_reg: a default 4-bit instance and an 8-bit instance resetting to 8'h3C,
// driven with directed and random reset/data patterns including mid-cycle disturbances.
module tb_dff_reg;

  logic       clk;
  logic       rst;
  logic [7:0] d;
  logic [3:0] q4;
  logic [7:0] q8;

  int n_tests = 0;
  int n_fail  = 0;

  dff_reg #(4) u_dut4 (
    .CLK (clk),
    .RST (rst),
    .D   (d[3:0]),
    .Q   (q4)
  );

  dff_reg #(.WIDTH(8), .RST_VAL(8'h3C)) u_dut8 (
    .CLK (clk),
    .RST (rst),
    .D   (d),
    .Q   (q8)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Entered 10 after a falling edge. Sets inputs 25 before the rising edge, checks the
  // captured value after it, then disturbs D and RST mid-cycle and checks Q still holds
  // after the following falling edge.
  task automatic cycle(input logic r, input logic [7:0] din, input int idx);
    logic [3:0] exp4;
    logic [7:0] exp8;
    #15;
    rst = r;
    d   = din;
    exp4 = r ? 4'h0  : din[3:0];
    exp8 = r ? 8'h3C : din;
    #35;
    check($sformatf("w4_capture_%0d", idx), {28'd0, q4}, {28'd0, exp4});
    check($sformatf("w8_capture_%0d", idx), {24'd0, q8}, {24'd0, exp8});
    #10;
    d   = 8'($urandom);
    rst = 1'($urandom);
    #40;
    check($sformatf("w4_hold_%0d", idx), {28'd0, q4}, {28'd0, exp4});
    check($sformatf("w8_hold_%0d", idx), {24'd0, q8}, {24'd0, exp8});
  endtask

  initial begin
    int idx;
    rst = 1'b1;
    d   = 8'hAA;
    idx = 0;
    #10;
    // Reset for two edges with D=A: Q must show the reset value, never A.
    cycle(1'b1, 8'hAA, idx++);
    cycle(1'b1, 8'hAA, idx++);
    // Incrementing data stream, one value per edge.
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 8'(i * 17), idx++);
    end
    // Reset mid-stream with D=5, then release: first edge without reset loads D.
    cycle(1'b1, 8'h05, idx++);
    cycle(1'b0, 8'h05, idx++);
    // Every bit must pass through.
    cycle(1'b0, 8'hFF, idx++);
    cycle(1'b0, 8'h00, idx++);
    cycle(1'b1, 8'hFF, idx++);
    cycle(1'b0, 8'h3C, idx++);
    // Random reset/data mix.
    for (int i = 0; i < 200; i++) begin
      cycle(($urandom_range(0, 7) == 0), 8'($urandom), idx++);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
